// File: rtl/sram_access_ctrl.sv
// Multi-cycle SRAM access controller: stalls the pipeline while a load/store runs for WAIT_CYCLES.
// Optional stall counter output enabled by defining SRAM_STALL_COUNT_EN.
`timescale 1ns/1ps
module sram_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [31:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  input  logic [31:0] sram_dq_in
`ifdef SRAM_STALL_COUNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             op_wr;
  logic             latch_req;
  logic             xfer_end;

  // Byte-lane and high address bits carry no meaning for the word-wide SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:20], addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state; ready is combinational so the pipeline freezes in the request cycle itself.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b1;
    latch_req = 1'b0;
    xfer_end  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_r_en || mem_w_en) begin
          ready     = 1'b0;
          latch_req = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        ready = 1'b0;
        if (cnt == '0) begin
          xfer_end  = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Transfer datapath: strobes are asserted from the edge entering ACCESS to the edge leaving it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data     <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      op_wr       <= 1'b0;
    end else begin
      if (latch_req) begin
        sram_addr   <= addr[19:2];
        sram_dq_out <= wr_data;
        op_wr       <= mem_w_en;
        sram_we_n   <= ~mem_w_en;
        sram_dq_oe  <= mem_w_en;
      end
      if (xfer_end) begin
        sram_we_n  <= 1'b1;
        sram_dq_oe <= 1'b0;
        if (!op_wr) begin
          rd_data <= sram_dq_in;
        end
      end
    end
  end

`ifdef SRAM_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (!ready) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 4, giving the number of SRAM access cycles per transfer (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port mem_r_en, input, 1 bit: read request from the EXE/MEM pipeline register.
REQ-005 The block SHALL have port mem_w_en, input, 1 bit: write request from the EXE/MEM pipeline register.
REQ-006 The block SHALL have port addr, input, 32 bits: byte address, taken from the ALU result.
REQ-007 The block SHALL have port wr_data, input, 32 bits: store data, taken from the Rm value.
REQ-008 The block SHALL have port rd_data, output, 32 bits: last word read from SRAM.
REQ-009 The block SHALL have port ready, output, 1 bit: 0 freezes all pipeline registers; 1 lets them advance.
REQ-010 The block SHALL have port sram_addr, output, 18 bits: SRAM word address.
REQ-011 The block SHALL have port sram_dq_out, output, 32 bits: write data to SRAM.
REQ-012 The block SHALL have port sram_dq_oe, output, 1 bit: drive enable for sram_dq_out.
REQ-013 The block SHALL have port sram_we_n, output, 1 bit: SRAM write strobe, active-low.
REQ-014 The block SHALL have port sram_dq_in, input, 32 bits: read data from SRAM.

Function
REQ-015 The FSM SHALL have three states, IDLE, ACCESS and DONE, and a 4-bit down-counter.
REQ-016 In IDLE with mem_r_en=1 or mem_w_en=1, on the next edge the FSM SHALL latch addr, wr_data and the operation, load the counter with WAIT_CYCLES-1, and go to ACCESS.
REQ-017 In ACCESS the counter SHALL decrement each cycle; when it reaches 0, the FSM SHALL go to DONE on the next edge.
REQ-018 DONE SHALL last exactly one cycle, SHALL ignore the request inputs, and SHALL always return to IDLE.
REQ-019 ready SHALL be combinational: 0 in IDLE while a request is present; 0 in ACCESS; 1 otherwise.
REQ-020 A request seen at cycle 0 SHALL keep ready low for exactly WAIT_CYCLES+1 cycles, with ready=1 at cycle WAIT_CYCLES+1.
REQ-021 sram_addr SHALL equal latched addr[19:2]; addr[1:0] and addr[31:20] SHALL be ignored.
REQ-022 For a write, sram_we_n=0 and sram_dq_oe=1 SHALL hold during every ACCESS cycle, with sram_dq_out equal to latched wr_data.
REQ-023 Outside write ACCESS cycles, sram_we_n SHALL be 1 and sram_dq_oe SHALL be 0.
REQ-024 For a read, rd_data SHALL capture sram_dq_in on the edge that leaves ACCESS and SHALL hold that value until the next read capture.
REQ-025 When mem_r_en and mem_w_en are both 1, the write SHALL take priority and no read capture SHALL occur.
REQ-026 A back-to-back request present in the cycle after DONE SHALL start a new transfer with no extra idle cycle.

Reset
REQ-027 When rst=0 at a clock edge, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-028 On reset, rd_data SHALL clear to 0, sram_addr to 0 and sram_dq_out to 0; sram_we_n SHALL become 1 and sram_dq_oe 0.
REQ-029 Reset asserted mid-ACCESS SHALL abort the transfer: no rd_data update, and sram_we_n deasserted in the next cycle.

Configuration
REQ-030 With macro SRAM_STALL_COUNT_EN defined, the block SHALL add output stall_cnt (32 bits), incrementing each cycle ready=0, wrapping 0xFFFFFFFF->0, and cleared by reset.
REQ-031 Without SRAM_STALL_COUNT_EN, the stall_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 The bench SHALL cover read with WAIT_CYCLES=4 and addr=0x00000410, sram_dq_in=0xDEADBEEF -> sram_addr=0x104; ready low for 5 cycles; rd_data=0xDEADBEEF when ready rises.
REQ-033 The bench SHALL cover write with addr=0x8, wr_data=0x12345678 -> sram_we_n=0 and sram_dq_oe=1 for exactly 4 cycles; sram_dq_out=0x12345678; rd_data unchanged.
REQ-034 The bench SHALL cover back-to-back read then write -> second transfer enters ACCESS one cycle after DONE; total ready-low cycles = 10.
REQ-035 The bench SHALL cover rst=0 in the 2nd ACCESS cycle of a write -> next cycle IDLE, sram_we_n=1, ready=1, rd_data=0.
REQ-036 The bench SHALL cover mem_r_en=mem_w_en=1 -> a write is performed and rd_data is not updated.
REQ-037 The bench SHALL cover WAIT_CYCLES=1 with SRAM_STALL_COUNT_EN defined and three reads -> ready low for 2 cycles each; stall_cnt=6.
